// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// A load strobe captures a packed digit word, decimal points and the
// leading-zero blanking enable into shadow registers. A prescaler paces a
// digit scan. Every output is registered. The tick cycle between two digit
// slots is a blank "guard" cycle, which keeps the previous digit's segments
// from ghosting onto the next anode.

module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,      // 1..8
  parameter int REFRESH_DIV = 50000,  // clk cycles per digit slot, >= 2
  parameter bit HEX_MODE    = 1'b0    // 1: codes 10..15 show A,b,C,d,E,F
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  // Active-low {a,b,c,d,e,f,g} pattern for one 4-bit code. Codes 10..15
  // blank unless hex display is enabled, so a stray code never lights all
  // segments.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = HEX_MODE ? 7'b0001000 : SEG_BLANK;
      4'hB:    seg = HEX_MODE ? 7'b1100000 : SEG_BLANK;
      4'hC:    seg = HEX_MODE ? 7'b0110001 : SEG_BLANK;
      4'hD:    seg = HEX_MODE ? 7'b1000010 : SEG_BLANK;
      4'hE:    seg = HEX_MODE ? 7'b0110000 : SEG_BLANK;
      4'hF:    seg = HEX_MODE ? 7'b0111000 : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Scan timing state
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick;

  // Shadow copy of the display value
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    sh_lz_q, sh_lz_d;

  // Registered pin drivers
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;

  // Per-digit helpers derived from the shadow value
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  zero_run;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] cur_anode;

  // Leading-zero mask: walk down from the most significant digit while
  // every digit seen so far is zero. Digit 0 is never blanked, so an
  // all-zero value still shows "0".
  // NOTE: every always_comb output gets a default before any branch or loop;
  // a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (sh_digits_q[4*i +: 4] == 4'h0);
      blank_vec[i] = sh_lz_q & zero_run & (i != 0);
    end
  end

  // Select the code, decimal point, blank flag and anode of the scanned digit.
  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_anode = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code     = sh_digits_q[4*i +: 4];
        cur_dp       = sh_dp_q[i];
        cur_blank    = blank_vec[i];
        cur_anode[i] = 1'b0;
      end
    end
  end

  // Prescaler and scan index. The index moves on only at the end of a slot.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shadow capture. New data shows up one edge after the load edge.
  always_comb begin
    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    sh_lz_d     = sh_lz_q;
    if (load) begin
      sh_digits_d = bcd;
      sh_dp_d     = dp_in;
      sh_lz_d     = blank_lz;
    end
  end

  // Next pin state: blank guard on the tick, otherwise the scanned digit.
  // Blanking hides segments only; the decimal point stays under its own control.
  always_comb begin
    if (tick) begin
      anode_d = '1;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
    end else begin
      anode_d = cur_anode;
      seg_d   = cur_blank ? SEG_BLANK : decode(cur_code);
      dp_d    = ~cur_dp;
    end
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the shadow registers are reset too; the display must show a
  // defined "0" straight out of reset instead of random power-up codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q       <= '0;
      idx_q       <= '0;
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_lz_q     <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      anode_q     <= '1;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_lz_q     <= sh_lz_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      anode_q     <= anode_d;
    end
  end

  assign segment = seg_q;
  assign dp      = dp_q;
  assign anode   = anode_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (decimal-only and hex) share
// stimulus. A timeline model derives the expected pins from the number of
// edges since reset and the captured display value.
`timescale 1ns/1ps

module tb_seven_seg_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [15:0]   bcd;
  logic [ND-1:0] dp_in;
  logic          blank_lz;

  logic [6:0]    seg_dec, seg_hex;
  logic          dp_dec, dp_hex;
  logic [ND-1:0] an_dec, an_hex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .HEX_MODE(1'b0)) u_dec (
    .clk(clk), .rst(rst), .load(load), .bcd(bcd), .dp_in(dp_in),
    .blank_lz(blank_lz), .segment(seg_dec), .dp(dp_dec), .anode(an_dec)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst(rst), .load(load), .bcd(bcd), .dp_in(dp_in),
    .blank_lz(blank_lz), .segment(seg_hex), .dp(dp_hex), .anode(an_hex)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Segment pattern for a code, straight from the glyph table.
  function automatic logic [6:0] glyph(input logic [3:0] code, input bit hex);
    logic [6:0] tab [16];
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    if (code > 4'd9 && !hex) return 7'b1111111;
    return tab[code];
  endfunction

  // ---------------- timeline model ----------------
  int          t;          // non-reset edges since the last reset
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_lz;
  logic [6:0]  exp_seg_dec, exp_seg_hex;
  logic        exp_dp;
  logic [3:0]  exp_an;
  bit          exp_valid = 1'b0;
  int          m_pre, m_idx;
  logic [15:0] m_up;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_val = '0; m_dp = '0; m_lz = 1'b0;
      exp_seg_dec = 7'h7F; exp_seg_hex = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
    end else begin
      m_pre = t % DIV;
      m_idx = (t / DIV) % ND;
      if (m_pre == DIV - 1) begin
        exp_seg_dec = 7'h7F; exp_seg_hex = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
      end else begin
        m_up = m_val >> (4 * m_idx);
        exp_an = 4'hF;
        exp_an[m_idx] = 1'b0;
        if (m_idx > 0 && m_lz && m_up == 16'h0) begin
          exp_seg_dec = 7'h7F; exp_seg_hex = 7'h7F;
        end else begin
          exp_seg_dec = glyph(m_up[3:0], 1'b0);
          exp_seg_hex = glyph(m_up[3:0], 1'b1);
        end
        exp_dp = ~m_dp[m_idx];
      end
      if (load) begin
        m_val = bcd; m_dp = dp_in; m_lz = blank_lz;
      end
      t++;
    end
    exp_valid = 1'b1;
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("seg_dec", seg_dec, exp_seg_dec);
      check("seg_hex", seg_hex, exp_seg_hex);
      check("dp_dec",  dp_dec,  exp_dp);
      check("dp_hex",  dp_hex,  exp_dp);
      check("an_dec",  an_dec,  exp_an);
      check("an_hex",  an_hex,  exp_an);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    @(negedge clk);
    load = 1'b1; bcd = v; dp_in = d; blank_lz = lz;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Bounded wait for a given anode pattern; returns #1 after the edge.
  task automatic wait_anode(input logic [3:0] want, input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (an_dec !== want && n < 40);
    check(name, an_dec, want);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bcd = '0; dp_in = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);

    // 1. reset release then scan of an all-zero value
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_an",  an_dec,  4'b1110);
    check("first_seg", seg_dec, 7'b0000001);
    repeat (20) @(negedge clk);

    // 2. load and decode
    do_load(16'h9876, 4'b0100, 1'b0);
    wait_anode(4'b1110, "w_9876_d0");
    check("d0_six",   seg_dec, 7'b0100000);
    check("d0_dp",    dp_dec,  1'b1);
    wait_anode(4'b1011, "w_9876_d2");
    check("d2_eight", seg_dec, 7'b0000000);
    check("d2_dp",    dp_dec,  1'b0);
    wait_anode(4'b0111, "w_9876_d3");
    check("d3_nine",  seg_dec, 7'b0000100);

    // 3. out-of-range / hex codes
    do_load(16'hFA00, 4'b0000, 1'b0);
    wait_anode(4'b0111, "w_fa_d3");
    check("fa_d3_dec", seg_dec, 7'b1111111);
    check("fa_d3_hex", seg_hex, 7'b0111000);
    wait_anode(4'b1011, "w_fa_d2");
    check("fa_d2_dec", seg_dec, 7'b1111111);
    check("fa_d2_hex", seg_hex, 7'b0001000);

    // 4. leading-zero blanking
    do_load(16'h0050, 4'b0000, 1'b1);
    wait_anode(4'b0111, "w_lz_d3");
    check("lz_d3", seg_dec, 7'b1111111);
    wait_anode(4'b1011, "w_lz_d2");
    check("lz_d2", seg_dec, 7'b1111111);
    wait_anode(4'b1101, "w_lz_d1");
    check("lz_d1", seg_dec, 7'b0100100);
    wait_anode(4'b1110, "w_lz_d0");
    check("lz_d0", seg_dec, 7'b0000001);
    do_load(16'h0000, 4'b0000, 1'b1);
    wait_anode(4'b1101, "w_z_d1");
    check("z_d1", seg_dec, 7'b1111111);
    wait_anode(4'b1110, "w_z_d0");
    check("z_d0", seg_dec, 7'b0000001);

    // 5. load on the tick edge: guard, then new data immediately
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while ((t % DIV) != DIV - 1 && n < 10);
      load = 1'b1; bcd = 16'h2222; dp_in = 4'b0000; blank_lz = 1'b0;
      @(posedge clk); #1;
      check("tick_load_an",  an_dec,  4'b1111);
      check("tick_load_seg", seg_dec, 7'b1111111);
      @(negedge clk);
      load = 1'b0;
      @(posedge clk); #1;
      check("after_tick_seg", seg_dec, 7'b0010010);
    end

    // Randomized traffic with occasional reset, checked by the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < ND; k++)
        bcd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0;

    // 6. reset in the middle of a slot
    do_load(16'h9876, 4'b0100, 1'b0);
    wait_anode(4'b1011, "w_rst_d2");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_an",  an_dec,  4'b1111);
    check("rst_seg", seg_dec, 7'b1111111);
    check("rst_dp",  dp_dec,  1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_an",  an_dec,  4'b1110);
    check("post_rst_seg", seg_dec, 7'b0000001);
    check("post_rst_dp",  dp_dec,  1'b1);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
